// File: rtl/dca_matrix_lsu_read_request_gen_if.sv
// Handshake bundle for the matrix LSU read-request generator: command in, AXI AR out, txn-info out.
// master = generator side, slave = environment (command source, AXI fabric, row collector).
interface dca_matrix_lsu_read_request_gen_if #(
  parameter int BW_ADDR      = 32,
  parameter int BW_AXI_DATA  = 32,
  parameter int BW_ROW_COUNT = 8,
  parameter int BW_ROW_BYTES = 8
);
  localparam int BW_BITADDR = $clog2(BW_AXI_DATA);
  localparam int BW_TXN     = 2 + 8 + BW_BITADDR;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [BW_ADDR-1:0]      cmd_base_addr;
  logic [BW_ADDR-1:0]      cmd_stride;
  logic [BW_ROW_COUNT-1:0] cmd_num_rows;
  logic [BW_ROW_BYTES-1:0] cmd_row_bytes;
  logic [BW_ROW_COUNT-1:0] cmd_num_pad_rows;

  logic                    rxarvalid;
  logic                    rxarready;
  logic [BW_ADDR-1:0]      rxaraddr;
  logic [7:0]              rxarlen;
  logic [2:0]              rxarsize;
  logic [1:0]              rxarburst;

  logic                    txn_valid;
  logic                    txn_ready;
  logic [BW_TXN-1:0]       txn_info;

  modport master (
    input  cmd_valid, cmd_base_addr, cmd_stride, cmd_num_rows, cmd_row_bytes, cmd_num_pad_rows,
    output cmd_ready,
    output rxarvalid, rxaraddr, rxarlen, rxarsize, rxarburst,
    input  rxarready,
    output txn_valid, txn_info,
    input  txn_ready
  );

  modport slave (
    output cmd_valid, cmd_base_addr, cmd_stride, cmd_num_rows, cmd_row_bytes, cmd_num_pad_rows,
    input  cmd_ready,
    input  rxarvalid, rxaraddr, rxarlen, rxarsize, rxarburst,
    output rxarready,
    input  txn_valid, txn_info,
    output txn_ready
  );
endinterface

// File: rtl/dca_matrix_lsu_read_request_gen.sv
// Matrix-load command -> one AXI AR burst plus one txn-info word per row, one command in flight.
// Optional macro DCA_LSU_PAD_ROW_EN appends cmd_num_pad_rows dummy txns after the real rows.
module dca_matrix_lsu_read_request_gen #(
  parameter int BW_ADDR          = 32,
  parameter int BW_AXI_DATA      = 32,
  parameter int MAX_NUM_AXI_DATA = 4,
  parameter int BW_ROW_COUNT     = 8,
  parameter int BW_ROW_BYTES     = 8
) (
  input  logic clk,
  input  logic rstnn,
  input  logic clear,
  input  logic enable,
  dca_matrix_lsu_read_request_gen_if.master bus,
  output logic busy,
  output logic done,
  output logic error
);

  localparam int BYTES_PER_BEAT = BW_AXI_DATA / 8;
  localparam int BW_OFF         = $clog2(BYTES_PER_BEAT);
  localparam int BW_BITADDR     = $clog2(BW_AXI_DATA);
  localparam int BW_SUM         = BW_ROW_BYTES + BW_OFF + 1;

`ifdef DCA_LSU_PAD_ROW_EN
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_PAD, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_FIN} state_t;
`endif

  state_t                  state_q, state_d;
  logic [BW_ADDR-1:0]      row_addr_q, row_addr_d;
  logic [BW_ADDR-1:0]      stride_q, stride_d;
  logic [BW_ROW_COUNT-1:0] num_rows_q, num_rows_d;
  logic [BW_ROW_COUNT-1:0] row_cnt_q, row_cnt_d;
  logic [BW_ROW_BYTES-1:0] row_bytes_q, row_bytes_d;
  logic [BW_ADDR-1:0]      araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [BW_BITADDR-1:0]   bitaddr_q, bitaddr_d;
  logic                    is_last_q, is_last_d;
  logic                    is_dummy_q, is_dummy_d;
  logic                    arvalid_q, arvalid_d;
  logic                    txn_valid_q, txn_valid_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
`ifdef DCA_LSU_PAD_ROW_EN
  logic [BW_ROW_COUNT-1:0] num_pad_q, num_pad_d;
  logic [BW_ROW_COUNT-1:0] pad_cnt_q, pad_cnt_d;
  logic [BW_ROW_COUNT-1:0] pad_cnt_nx;
  logic                    go_pad;
`else
  logic                    unused_pad;
  assign unused_pad = ^bus.cmd_num_pad_rows;
`endif

  logic                    ar_acc, txn_acc;
  logic [BW_OFF-1:0]       off;
  logic [BW_SUM-1:0]       span, beats;
  logic [BW_ROW_COUNT-1:0] row_cnt_nx;
  logic                    last_row;

  assign ar_acc     = arvalid_q   & bus.rxarready;
  assign txn_acc    = txn_valid_q & bus.txn_ready;
  assign off        = row_addr_q[BW_OFF-1:0];
  assign row_cnt_nx = row_cnt_q + 1'b1;
  assign last_row   = (row_cnt_q == num_rows_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    row_addr_d  = row_addr_q;
    stride_d    = stride_q;
    num_rows_d  = num_rows_q;
    row_cnt_d   = row_cnt_q;
    row_bytes_d = row_bytes_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    bitaddr_d   = bitaddr_q;
    is_last_d   = is_last_q;
    is_dummy_d  = is_dummy_q;
    arvalid_d   = arvalid_q;
    txn_valid_d = txn_valid_q;
    done_d      = 1'b0;
    error_d     = error_q;
    span        = BW_SUM'(off) + BW_SUM'(row_bytes_q) + BW_SUM'(BYTES_PER_BEAT - 1);
    beats       = span >> BW_OFF;
`ifdef DCA_LSU_PAD_ROW_EN
    num_pad_d   = num_pad_q;
    pad_cnt_d   = pad_cnt_q;
    pad_cnt_nx  = pad_cnt_q + 1'b1;
    go_pad      = 1'b0;
`endif

    if (clear) begin
      state_d     = S_IDLE;
      arvalid_d   = 1'b0;
      txn_valid_d = 1'b0;
      error_d     = 1'b0;
    end else if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            row_addr_d  = bus.cmd_base_addr;
            stride_d    = bus.cmd_stride;
            num_rows_d  = bus.cmd_num_rows;
            row_bytes_d = bus.cmd_row_bytes;
            row_cnt_d   = '0;
            error_d     = 1'b0;
`ifdef DCA_LSU_PAD_ROW_EN
            num_pad_d   = bus.cmd_num_pad_rows;
`endif
            if (bus.cmd_num_rows != '0) state_d = S_CALC;
`ifdef DCA_LSU_PAD_ROW_EN
            else if (bus.cmd_num_pad_rows != '0) go_pad = 1'b1;
`endif
            else state_d = S_FIN;
          end
        end
        S_CALC: begin
          // A zero-byte row still costs one beat so alen never wraps.
          if (beats == '0) beats = BW_SUM'(1);
          if (beats > BW_SUM'(MAX_NUM_AXI_DATA)) begin
            beats   = BW_SUM'(MAX_NUM_AXI_DATA);
            error_d = 1'b1;
          end
          araddr_d    = {row_addr_q[BW_ADDR-1:BW_OFF], {BW_OFF{1'b0}}};
          bitaddr_d   = {off, 3'b000};
          arlen_d     = 8'(beats - 1'b1);
          is_dummy_d  = 1'b0;
`ifdef DCA_LSU_PAD_ROW_EN
          is_last_d   = last_row && (num_pad_q == '0);
`else
          is_last_d   = last_row;
`endif
          arvalid_d   = 1'b1;
          txn_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
        S_ISSUE: begin
          // AR and txn retire independently; the row is done once both have gone.
          arvalid_d   = arvalid_q   & ~ar_acc;
          txn_valid_d = txn_valid_q & ~txn_acc;
          if (!arvalid_d && !txn_valid_d) begin
            row_addr_d = row_addr_q + stride_q;
            row_cnt_d  = row_cnt_nx;
            if (row_cnt_nx != num_rows_q) state_d = S_CALC;
`ifdef DCA_LSU_PAD_ROW_EN
            else if (num_pad_q != '0) go_pad = 1'b1;
`endif
            else state_d = S_FIN;
          end
        end
`ifdef DCA_LSU_PAD_ROW_EN
        S_PAD: begin
          if (txn_acc) begin
            pad_cnt_d = pad_cnt_nx;
            if (pad_cnt_nx == num_pad_q) begin
              txn_valid_d = 1'b0;
              state_d     = S_FIN;
            end else begin
              is_last_d = (pad_cnt_nx == num_pad_q - 1'b1);
            end
          end
        end
`endif
        S_FIN: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

`ifdef DCA_LSU_PAD_ROW_EN
      // Dummy rows carry no address; alen/bitaddr are forced to zero for the collector.
      if (go_pad) begin
        state_d     = S_PAD;
        pad_cnt_d   = '0;
        txn_valid_d = 1'b1;
        is_dummy_d  = 1'b1;
        arlen_d     = '0;
        bitaddr_d   = '0;
        is_last_d   = (num_pad_d == BW_ROW_COUNT'(1));
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= S_IDLE;
      row_addr_q  <= '0;
      stride_q    <= '0;
      num_rows_q  <= '0;
      row_cnt_q   <= '0;
      row_bytes_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      bitaddr_q   <= '0;
      is_last_q   <= 1'b0;
      is_dummy_q  <= 1'b0;
      arvalid_q   <= 1'b0;
      txn_valid_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef DCA_LSU_PAD_ROW_EN
      num_pad_q   <= '0;
      pad_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_addr_q  <= row_addr_d;
      stride_q    <= stride_d;
      num_rows_q  <= num_rows_d;
      row_cnt_q   <= row_cnt_d;
      row_bytes_q <= row_bytes_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      bitaddr_q   <= bitaddr_d;
      is_last_q   <= is_last_d;
      is_dummy_q  <= is_dummy_d;
      arvalid_q   <= arvalid_d;
      txn_valid_q <= txn_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef DCA_LSU_PAD_ROW_EN
      num_pad_q   <= num_pad_d;
      pad_cnt_q   <= pad_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rxarvalid = arvalid_q;
  assign bus.rxaraddr  = araddr_q;
  assign bus.rxarlen   = arlen_q;
  assign bus.rxarsize  = 3'(BW_OFF);
  assign bus.rxarburst = 2'b01;
  assign bus.txn_valid = txn_valid_q;
  assign bus.txn_info  = {is_dummy_q, is_last_q, arlen_q, bitaddr_q};
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign error         = error_q;

endmodule
